// File: rtl/display_pkg.sv
// Shared types and constants for the two-digit multiplexed display scheduler.
package display_pkg;

   localparam int HOLD_CYCLES_DEF  = 1000;
   localparam int BLANK_CYCLES_DEF = 10;

   // Active-low segments {g..a}; all ones is every segment dark.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      BLANK0 = 2'd0,
      SHOW0  = 2'd1,
      BLANK1 = 2'd2,
      SHOW1  = 2'd3
   } disp_state_t;

endpackage

// File: rtl/display_scheduler_if.sv
// Load handshake between a digit-pair requester and the display scheduler.
interface display_scheduler_if;

   logic       load_valid;
   logic       load_ready;
   logic [3:0] s0;
   logic [3:0] s1;

   modport master (
      output load_valid,
      output s0,
      output s1,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  s0,
      input  s1,
      output load_ready
   );

endinterface

// File: rtl/display_scheduler_sevenseg.sv
// Hex to active-low seven-segment glyph decoder, segment order {g..a}.
module sevensegment (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Glyph lookup; A-F use the usual A b C d E F shapes.
   always_comb begin
      seg = 7'b1111111;
      case (digit)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/display_scheduler.sv
// Two-digit multiplexed display scheduler with a blanking gap before each digit.
//
// state  | meaning
// -------+--------------------------------------------------------------
// BLANK0 | both digits dark; pair loads accepted; parks here while en=0
// SHOW0  | digit 0 lit for HOLD_CYCLES
// BLANK1 | both digits dark for BLANK_CYCLES
// SHOW1  | digit 1 lit for HOLD_CYCLES, then back to BLANK0
import display_pkg::*;

module display_scheduler #(
   parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
   parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   display_scheduler_if.slave  load,
   output logic                select,
   output logic                notselect,
   output logic [6:0]          seg,
   output logic [4:0]          led
);

   localparam int MAX_N = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
   localparam int CW    = ($clog2(MAX_N) < 1) ? 1 : $clog2(MAX_N);

   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   disp_state_t   state_q;
   disp_state_t   state_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] last;
   logic          at_last;
   logic [3:0]    d0_q;
   logic [3:0]    d1_q;
   logic [4:0]    led_q;
   logic          accept;
   logic [3:0]    digit;
   logic [6:0]    glyph;

   assign last    = (state_q == SHOW0 || state_q == SHOW1) ? HOLD_LAST : BLANK_LAST;
   assign at_last = (cnt_q == last);

   // Loads are only taken between frames so a frame never mixes two pairs.
   assign load.load_ready = (state_q == BLANK0) && reset;
   assign accept          = load.load_valid && load.load_ready;

   // State and dwell counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BLANK0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: dwell in each state, only the frame start looks at en.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
         BLANK0: begin
            if (!en) begin
               cnt_d = '0;
            end else if (at_last) begin
               state_d = SHOW0;
               cnt_d   = '0;
            end
         end
         SHOW0: begin
            if (at_last) begin
               state_d = BLANK1;
               cnt_d   = '0;
            end
         end
         BLANK1: begin
            if (at_last) begin
               state_d = SHOW1;
               cnt_d   = '0;
            end
         end
         SHOW1: begin
            if (at_last) begin
               state_d = BLANK0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = BLANK0;
            cnt_d   = '0;
         end
      endcase
   end

   // Latched digit pair and its registered sum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d0_q  <= 4'd0;
         d1_q  <= 4'd0;
         led_q <= 5'd0;
      end else if (accept) begin
         d0_q  <= load.s0;
         d1_q  <= load.s1;
         led_q <= {1'b0, load.s0} + {1'b0, load.s1};
      end
   end

   assign digit = (state_q == SHOW1) ? d1_q : d0_q;

   sevensegment u_sevensegment (
      .digit (digit),
      .seg   (glyph)
   );

   // Moore output decode straight from the current state.
   always_comb begin
      select    = 1'b0;
      notselect = 1'b0;
      seg       = SEG_BLANK;
      case (state_q)
         SHOW0: begin
            select = 1'b1;
            seg    = glyph;
         end
         SHOW1: begin
            notselect = 1'b1;
            seg       = glyph;
         end
         default: begin
            seg = SEG_BLANK;
         end
      endcase
   end

   assign led = led_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with a frame-position reference model.
module tb_display_scheduler;

   localparam int H = 4;
   localparam int B = 2;
   localparam int P = 2 * (H + B);

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       select;
   logic       notselect;
   logic [6:0] seg;
   logic [4:0] led;

   display_scheduler_if ifc ();

   display_scheduler #(.HOLD_CYCLES(H), .BLANK_CYCLES(B)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .load      (ifc),
      .select    (select),
      .notselect (notselect),
      .seg       (seg),
      .led       (led)
   );

   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [14:0] exp_q[$];

   // Model: one position within a P-cycle frame, plus latched pair and sum.
   int         pos = 0;
   logic [3:0] md0 = 4'd0;
   logic [3:0] md1 = 4'd0;
   logic [4:0] mled = 5'd0;
   bit         rst_v = 1'b0;
   bit         en_v = 1'b0;
   bit         req_pending = 1'b0;
   logic [3:0] req_s0 = 4'd0;
   logic [3:0] req_s1 = 4'd0;

   // Lit segments of each hex glyph, by segment letter.
   string LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   function automatic logic [6:0] glyph(logic [3:0] d);
      logic [6:0] v;
      string      s;
      int         idx;
      v = 7'h7f;
      s = LIT[d];
      for (int i = 0; i < s.len(); i++) begin
         idx = int'(s[i]) - 97;
         v[idx[2:0]] = 1'b0;
      end
      return v;
   endfunction

   function automatic logic [14:0] expect_now();
      logic       sel;
      logic       nsel;
      logic [6:0] sg;
      sel  = 1'b0;
      nsel = 1'b0;
      sg   = 7'h7f;
      if (pos >= B && pos < B + H) begin
         sel = 1'b1;
         sg  = glyph(md0);
      end else if (pos >= 2 * B + H) begin
         nsel = 1'b1;
         sg   = glyph(md1);
      end
      return {rst_v && (pos < B), sel, nsel, sg, mled};
   endfunction

   function automatic logic [14:0] actual_now();
      return {ifc.load_ready, select, notselect, seg, led};
   endfunction

   task automatic chk(string name, logic [14:0] act, logic [14:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Drive one cycle of inputs, advance the model across the coming edge.
   task automatic cycle();
      reset          = rst_v;
      en             = en_v;
      ifc.load_valid = req_pending;
      ifc.s0         = req_pending ? req_s0 : 4'($urandom_range(0, 15));
      ifc.s1         = req_pending ? req_s1 : 4'($urandom_range(0, 15));
      if (!rst_v) begin
         pos  = 0;
         md0  = 4'd0;
         md1  = 4'd0;
         mled = 5'd0;
      end else begin
         if (req_pending && pos < B) begin
            md0         = req_s0;
            md1         = req_s1;
            mled        = {1'b0, req_s0} + {1'b0, req_s1};
            req_pending = 1'b0;
         end
         if (pos < B && !en_v) pos = 0;
         else pos = (pos + 1) % P;
      end
      exp_q.push_back(expect_now());
      @(negedge clk);
   endtask

   task automatic run(int n);
      repeat (n) cycle();
   endtask

   task automatic offer(logic [3:0] a, logic [3:0] b);
      int guard;
      guard       = 0;
      req_pending = 1'b1;
      req_s0      = a;
      req_s1      = b;
      while (req_pending && guard < 200) begin
         cycle();
         guard++;
      end
      if (req_pending) begin
         n_total++;
         $display("FAIL accept_timeout: still pending after %0d cycles, required accepted", guard);
         req_pending = 1'b0;
      end
   endtask

   task automatic run_until(int lo, int hi);
      int guard;
      guard = 0;
      while (!(pos >= lo && pos <= hi) && guard < 100) begin
         cycle();
         guard++;
      end
      if (!(pos >= lo && pos <= hi)) begin
         n_total++;
         $display("FAIL frame_position: got %0d required %0d..%0d", pos, lo, hi);
      end
   endtask

   // Monitor: compare every post-edge output against the scoreboard.
   initial begin
      logic [14:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", actual_now(), e);
         end
         chk("exclusive_select", {14'd0, select & notselect}, 15'd0);
      end
   end

   initial begin
      reset          = 1'b0;
      en             = 1'b0;
      ifc.load_valid = 1'b0;
      ifc.s0         = 4'd0;
      ifc.s1         = 4'd0;
      #2;
      chk("reset_state", actual_now(), {3'b000, 7'h7f, 5'd0});

      @(negedge clk);
      rst_v = 1'b1;
      en_v  = 1'b1;
      reset = 1'b1;
      en    = 1'b1;
      #1;
      chk("ready_after_release", {14'd0, ifc.load_ready}, 15'd1);

      // Free-running frames with the zero pair.
      run(2 * P);

      // Largest pair: sum 30 and F glyph on both digits.
      offer(4'hF, 4'hF);
      run(P);

      // Offer made mid-SHOW0 waits for the next BLANK0.
      run_until(B, B);
      offer(4'd3, 4'd5);
      run(P);

      // en dropped in SHOW0: frame completes then parks.
      run_until(B, B);
      en_v = 1'b0;
      run(30);
      en_v = 1'b1;
      run(2 * P);

      // Every pair in turn, with occasional parking.
      for (int i = 0; i < 256; i++) begin
         en_v = ($urandom_range(0, 7) != 0);
         offer(4'(i >> 4), 4'(i));
         en_v = 1'b1;
         run(P);
         repeat ($urandom_range(0, 3)) begin
            en_v = ($urandom_range(0, 3) != 0);
            cycle();
         end
      end

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         en_v = ($urandom_range(0, 7) != 0);
         if (!req_pending && $urandom_range(0, 9) == 0) begin
            req_pending = 1'b1;
            req_s0      = 4'($urandom_range(0, 15));
            req_s1      = 4'($urandom_range(0, 15));
         end
         cycle();
      end
      req_pending = 1'b0;

      // Asynchronous reset in the middle of SHOW1.
      en_v = 1'b1;
      offer(4'd9, 4'd9);
      run_until(2 * B + H + 1, 2 * B + H + 2);
      #2;
      rst_v = 1'b0;
      reset = 1'b0;
      #1;
      chk("async_reset_mid_show1", actual_now(), {3'b000, 7'h7f, 5'd0});
      cycle();
      rst_v = 1'b1;
      run(2 * P);

      repeat (2) @(posedge clk);
      #2;
      chk("queue_drained", 15'(exp_q.size()), 15'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, clocks each digit stays lit per frame; legal values are 1 or greater.
REQ-002 Parameter BLANK_CYCLES, default 10, clocks of dead time (both digits off) before each digit is lit; legal values are 1 or greater.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 en  input  1  1 = keep refreshing; 0 = park blanked at the next frame boundary.
REQ-006 s0  input  4  digit-0 value, sampled only on an accepted load.
REQ-007 s1  input  4  digit-1 value, sampled only on an accepted load.
REQ-008 load_valid  input  1  requester offers a new s0/s1 pair.
REQ-009 load_ready  output  1  block can accept a pair this cycle.
REQ-010 select  output  1  1 = digit 0 lit.
REQ-011 notselect  output  1  1 = digit 1 lit.
REQ-012 seg  output  7  active-low segments {g..a} for the lit digit.
REQ-013 led  output  5  registered sum of the latched pair.

Function
REQ-014 The FSM SHALL have states BLANK0, SHOW0, BLANK1 and SHOW1, visited in the cycle BLANK0 -> SHOW0 -> BLANK1 -> SHOW1 -> BLANK0.
REQ-015 A dwell counter SHALL count 0..N-1 in each state (N = BLANK_CYCLES in BLANKx, HOLD_CYCLES in SHOWx), then advance the state and return to 0 on the same edge.
REQ-016 In BLANK0, the exit at terminal count SHALL require en=1; with en=0 the FSM stays in BLANK0 and the counter holds at 0.
REQ-017 en SHALL be ignored in SHOW0, BLANK1 and SHOW1, so a started frame always completes.
REQ-018 Outputs SHALL be Moore decodes of the current state and latched digits, with no pipeline lag:
  - SHOW0: select=1, notselect=0, seg=decode(d0).
  - SHOW1: select=0, notselect=1, seg=decode(d1).
  - BLANKx: select=0, notselect=0, seg=7'b1111111.
REQ-019 select and notselect SHALL never both be 1 in any cycle.
REQ-020 load_ready SHALL be 1 exactly when the state is BLANK0 and reset is deasserted, so a frame never shows a mixed pair.
REQ-021 On an edge with load_valid and load_ready both 1, the block SHALL set d0<=s0, d1<=s1 and led<={1'b0,s0}+{1'b0,s1}, visible from the next cycle.
REQ-022 A load SHALL NOT disturb the state or the dwell counter.
REQ-023 led SHALL be 5 bits and never truncate; the maximum value is 15+15 = 30.
REQ-024 With load_valid=1 outside BLANK0, the block SHALL ignore the pair; the requester holds it until ready.

Reset
REQ-025 Reset assertion SHALL asynchronously force the following, including mid-frame:
  - state = BLANK0 and counter = 0.
  - d0 = d1 = 0 and led = 0.
  - select = notselect = 0, seg = 7'b1111111, load_ready = 0.
REQ-026 After reset release, the first rising edge SHALL see load_ready=1, and the first SHOW0 SHALL begin BLANK_CYCLES edges later if en=1.

Structure
REQ-027 A shared package display_pkg SHALL hold:
  - the state enum.
  - the HOLD_CYCLES and BLANK_CYCLES defaults.
  - the SEG_BLANK constant 7'b1111111.
REQ-028 The counter width SHALL be $clog2 of the larger of HOLD_CYCLES and BLANK_CYCLES, with a minimum of 1.
REQ-029 The block SHALL instantiate exactly one sevensegment decoder, fed by the digit mux; the decoder is active-low, maps 0 -> 7'b1000000 and 8 -> 7'b0000000, and has hex glyphs for A-F.

Verification (HOLD_CYCLES=4, BLANK_CYCLES=2)
REQ-030 Reset release with en=1 and no load -> the bench sees:
  - BLANK0 for 2 cycles, then select=1 with seg=1000000 for 4 cycles.
  - 2 blank cycles, then notselect=1 with seg=1000000 for 4 cycles.
  - a period of 12 cycles.
REQ-031 Load s0=F, s1=F in BLANK0 -> next cycle led=30, and the following SHOW0/SHOW1 show seg=0001110 on each digit.
REQ-032 load_valid held with s0=3, s1=5 asserted during SHOW0 -> load_ready=0 until the next BLANK0, acceptance there, then led=8.
REQ-033 en dropped during SHOW0 -> the frame finishes SHOW1, then the FSM stays in BLANK0 with all outputs blank; en=1 again -> SHOW0 starts 2 cycles later.
REQ-034 reset asserted in the middle of SHOW1 -> in the same cycle select=notselect=0, seg=1111111, led=0, without waiting for a clock edge.
REQ-035 All 256 pairs loaded in turn -> each frame checks led = s0+s1, checks seg per lit digit, and checks that select and notselect are never both 1.
